mem_bist_ctrl: RTL and testbench
================================

# mem_bist_ctrl

Built-in self-test controller that sits directly upstream of the 256×16 single-port memory and drives its data, address-bit and WEn inputs. On `start` it runs a four-phase write/read-compare sweep using a seeded address-derived pattern and its inverse. It counts mismatches on the memory's combinational read data and reports pass/fail with the first failing address. It owns the memory port only while `busy`; a system mux outside this block selects between the BIST and the functional master.

## Interface
- `ADDR_W`, 8, memory address width (depth = 2**ADDR_W = 256)
- `DATA_W`, 16, memory word width
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a run; sampled only in IDLE or DONE
- `abort`  in  1  terminate a run in progress; ignored when not busy
- `seed`  in  DATA_W  pattern seed; latched on accepted `start`
- `mem_data`  out  DATA_W  write data to memory `data`
- `mem_addr`  out  ADDR_W  address; bit i drives memory `addr<i>`
- `mem_wen`  out  1  write enable to memory `WEn`
- `mem_q`  in  DATA_W  memory `qout` (combinational read of `mem_addr`)
- `busy`  out  1  run in progress
- `done`  out  1  run completed; held until next accepted `start`
- `pass`  out  1  valid when `done`; 1 iff `err_count` == 0
- `err_count`  out  10  mismatches this run (max 512, no saturation needed)
- `first_err_addr`  out  ADDR_W  address of first mismatch; valid when `err_count` != 0

## Operation
- Pattern: P(k) = {k, ~k} XOR seed_latched (k = 8-bit address).
- States: IDLE -> W0 -> R0 -> W1 -> R1 -> DONE.
  - W0: mem_wen=1, mem_data=P(addr); addr 0..255.
  - R0: mem_wen=0; compare mem_q against P(addr) every cycle.
  - W1: mem_wen=1, mem_data=~P(addr).
  - R1: compare mem_q against ~P(addr).
- Address counter resets to 0 on entry to each phase; phase advances when addr==255 (wrap to 0 is the transition, not a repeat).
- Mismatch: err_count += 1; if err_count was 0, first_err_addr <= addr.
- IDLE/DONE + `start`: latch seed, clear err_count, first_err_addr, done, pass; enter W0.
- `start` while busy: ignored.
- `abort` while busy: next state IDLE, busy=0, done=0, mem_wen=0; err_count keeps its partial value.
- `abort` and `start` same cycle while busy: abort wins; `start` ignored.
- mem_data driven as 0 and mem_wen=0 outside write phases.

## Timing
- Reset values: state IDLE, mem_addr 0, mem_data 0, mem_wen 0, busy 0, done 0, pass 0, err_count 0, first_err_addr 0, seed_latched 0.
- `start` high at edge N -> busy=1, W0, addr 0 from edge N; write of addr k occurs at edge N+1+k.
- Each phase 256 cycles; R1 ends with compare at addr 255 in cycle N+1023; done=1, pass valid, busy=0 after edge N+1024.
- Compare is same-cycle on combinational mem_q; result registered into counters at the same edge that advances addr.
- `rst_n` low mid-run: all outputs return to reset values asynchronously; mem_wen deasserts immediately.

## Structure
- Package `mem_bist_pkg`: state enum (IDLE, W0, R0, W1, R1, DONE), ADDR_W/DATA_W defaults, err_count width, pattern function P(k, seed).
- One sub-module: `mem_bist_pattern` (combinational; inputs addr, seed, invert; output expected word) shared by write-data and compare paths.

## Test plan
- Fault-free memory model, seed 0x0000: start at cycle 0 -> done at cycle 1024, pass=1, err_count=0; memory addr 0x12 ends holding ~{0x12,0xED}=0xED12.
- Bit 3 of addr 0x37 stuck-at-0, seed 0xA5A5 -> err_count=1, first_err_addr=0x37, pass=0.
- Addr bit 5 shorted to bit 4 (aliasing), seed 0 -> err_count > 0, first_err_addr is the lowest aliased address read in R0.
- Abort asserted at cycle 300 (R0) -> busy=0 and mem_wen=0 next cycle, done=0; subsequent start completes normally with pass=1.
- rst_n pulsed low at cycle 600 -> outputs at reset values same cycle; start pulses during busy are ignored (done still at cycle 1024 of original run).
- Back-to-back runs: start asserted in DONE with seed 0xFFFF -> done and pass cleared next cycle, new run completes with pass=1.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller.
// The pattern is the address concatenated with its complement, XORed with the latched seed.
package mem_bist_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;
   localparam int ERR_W      = 10;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      W0   = 3'd1,
      R0   = 3'd2,
      W1   = 3'd3,
      R1   = 3'd4,
      DONE = 3'd5
   } state_t;

   function automatic logic [DEF_DATA_W-1:0] bist_pattern(input logic [DEF_ADDR_W-1:0] k,
                                                          input logic [DEF_DATA_W-1:0] seed);
      return {k, ~k} ^ seed;
   endfunction

endpackage

// File: rtl/mem_bist_pattern.sv
// Expected-word generator. The write-data path and the read-compare path both use it,
// so the word that is written and the word that is checked cannot diverge.
module mem_bist_pattern
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] seed,
   input  logic              invert,
   output logic [DATA_W-1:0] expected
);

   assign expected = ({addr, ~addr} ^ seed) ^ {DATA_W{invert}};

endmodule

// File: rtl/mem_bist_ctrl.sv
// Four-phase write/read-compare BIST sweep over a single-port memory.
// The memory port is driven only while busy; the read compare uses same-cycle mem_q.
//
// state | meaning
// IDLE  | waiting for start, memory port quiet
// W0    | write P(addr) to every address
// R0    | read every address, compare with P(addr)
// W1    | write ~P(addr) to every address
// R1    | read every address, compare with ~P(addr)
// DONE  | result valid, held until the next start
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] seed,
   output logic [DATA_W-1:0] mem_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   state_t state, state_nxt;

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] seed_lat;
   logic [DATA_W-1:0] expected;
   logic              run_phase;
   logic              write_phase;
   logic              read_phase;
   logic              invert;
   logic              last_addr;
   logic              accept_start;
   logic              mismatch;

   assign write_phase  = (state == W0) || (state == W1);
   assign read_phase   = (state == R0) || (state == R1);
   assign run_phase    = write_phase || read_phase;
   assign invert       = (state == W1) || (state == R1);
   assign last_addr    = &addr;
   assign accept_start = start && ((state == IDLE) || (state == DONE));

   mem_bist_pattern #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pattern (
      .addr     (addr),
      .seed     (seed_lat),
      .invert   (invert),
      .expected (expected)
   );

   assign mismatch = (mem_q != expected);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: if (start)     state_nxt = W0;
         W0:         if (last_addr) state_nxt = R0;
         R0:         if (last_addr) state_nxt = W1;
         W1:         if (last_addr) state_nxt = R1;
         R1:         if (last_addr) state_nxt = DONE;
         default:                   state_nxt = IDLE;
      endcase
      // abort outranks both phase advance and a coincident start
      if (run_phase && abort) begin
         state_nxt = IDLE;
      end
   end

   // Address wraps 255->0 on the same edge the phase advances, so each phase restarts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr           <= '0;
         seed_lat       <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (accept_start) begin
         addr           <= '0;
         seed_lat       <= seed;
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (run_phase) begin
         if (abort) begin
            addr <= '0;
         end else begin
            addr <= addr + 1'b1;
            if (read_phase && mismatch) begin
               err_count <= err_count + 1'b1;
               if (err_count == '0) begin
                  first_err_addr <= addr;
               end
            end
         end
      end
   end

   assign mem_addr = addr;
   assign mem_wen  = write_phase;
   assign mem_data = write_phase ? expected : '0;
   assign busy     = run_phase;
   assign done     = (state == DONE);
   assign pass     = done && (err_count == '0);

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench for mem_bist_ctrl: memory model with injectable faults and a
// sweep-level reference model that predicts error count and first failing address.
module tb_mem_bist_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] seed;
   logic [15:0] mem_data;
   logic [7:0]  mem_addr;
   logic        mem_wen;
   logic [15:0] mem_q;
   logic        busy;
   logic        done;
   logic        pass;
   logic [9:0]  err_count;
   logic [7:0]  first_err_addr;

   int checks;
   int failures;
   int fault_mode;   // 0 none, 1 bit3 of addr 0x37 stuck-at-0, 2 addr bit5 shorted to bit4

   logic [15:0] mem [256];

   mem_bist_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .seed           (seed),
      .mem_data       (mem_data),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_q          (mem_q),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] eff(input logic [7:0] k, input int fm);
      if (fm == 2) return {k[7:6], k[4], k[4:0]};
      return k;
   endfunction

   always @(posedge clk) begin
      if (mem_wen) mem[eff(mem_addr, fault_mode)] <= mem_data;
   end

   always_comb begin
      mem_q = mem[eff(mem_addr, fault_mode)];
      if (fault_mode == 1 && mem_addr == 8'h37) mem_q[3] = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   // Whole-sweep reference: four passes over an array, faults applied as in the memory model.
   task automatic model(input logic [15:0] s, input int fm, output int e, output logic [7:0] f);
      logic [15:0] m [256];
      logic [15:0] w;
      logic [15:0] q;
      logic [7:0]  a;
      e = 0;
      f = 8'h00;
      for (int i = 0; i < 256; i++) m[i] = 16'h0000;
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 256; k++) begin
            a = 8'(k);
            w = {a, ~a} ^ s;
            if (p >= 2) w = ~w;
            if (p % 2 == 0) begin
               m[eff(a, fm)] = w;
            end else begin
               q = m[eff(a, fm)];
               if (fm == 1 && a == 8'h37) q[3] = 1'b0;
               if (q !== w) begin
                  if (e == 0) f = a;
                  e++;
               end
            end
         end
      end
   endtask

   task automatic run_check(input string tag, input logic [15:0] s, input int fm, input bit poke);
      int          e;
      int          ph;
      logic [7:0]  f;
      logic [7:0]  a;
      logic [15:0] w;
      model(s, fm, e, f);
      @(negedge clk);
      fault_mode = fm;
      seed  = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      seed  = 16'($urandom);
      chk({tag, "_busy0"}, busy, 1'b1);
      chk({tag, "_done0"}, done, 1'b0);
      chk({tag, "_pass0"}, pass, 1'b0);
      chk({tag, "_err0"}, err_count, 10'd0);
      chk({tag, "_addr0"}, mem_addr, 8'h00);
      chk({tag, "_data0"}, mem_data, {8'h00, 8'hFF} ^ s);
      for (int c = 1; c < 1024; c++) begin
         @(negedge clk);
         start = poke && (c % 97 == 0);
         if (poke) seed = 16'($urandom);
         @(posedge clk);
         #1;
         if (c % 128 == 1) begin
            ph = c / 256;
            a  = 8'(c % 256);
            w  = {a, ~a} ^ s;
            if (ph >= 2) w = ~w;
            chk({tag, "_addr"}, mem_addr, a);
            chk({tag, "_wen"}, mem_wen, (ph % 2 == 0));
            chk({tag, "_data"}, mem_data, (ph % 2 == 0) ? w : 16'h0000);
         end
      end
      start = 1'b0;
      chk({tag, "_busy_last"}, busy, 1'b1);
      chk({tag, "_done_early"}, done, 1'b0);
      @(posedge clk);
      #1;
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_busy_end"}, busy, 1'b0);
      chk({tag, "_wen_end"}, mem_wen, 1'b0);
      chk({tag, "_err"}, err_count, 10'(e));
      chk({tag, "_first"}, first_err_addr, f);
      chk({tag, "_pass"}, pass, (e == 0));
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      fault_mode = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      seed       = 16'h0000;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_pass", pass, 1'b0);
      chk("rst_wen", mem_wen, 1'b0);
      chk("rst_data", mem_data, 16'h0000);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_err", err_count, 10'd0);
      chk("rst_first", first_err_addr, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("idle_abort_busy", busy, 1'b0);

      run_check("clean", 16'h0000, 0, 1'b0);
      chk("clean_mem12", mem[8'h12], 16'hED12);

      run_check("stuck", 16'hA5A5, 1, 1'b0);
      chk("stuck_err1", err_count, 10'd1);
      chk("stuck_first", first_err_addr, 8'h37);

      run_check("alias", 16'h0000, 2, 1'b1);
      chk("alias_nonzero", (err_count != 10'd0), 1'b1);

      // abort (with coincident start) in R0 at cycle 300
      @(negedge clk);
      fault_mode = 0;
      seed  = 16'h1234;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (299) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_wen", mem_wen, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_data", mem_data, 16'h0000);
      chk("abort_err", err_count, 10'd0);
      @(posedge clk);
      #1;
      chk("abort_stay_idle", busy, 1'b0);
      run_check("after_abort", 16'($urandom), 0, 1'b0);

      // asynchronous reset in the middle of a run
      @(negedge clk);
      seed  = 16'h0F0F;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (599) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_wen", mem_wen, 1'b0);
      chk("arst_data", mem_data, 16'h0000);
      chk("arst_addr", mem_addr, 8'h00);
      chk("arst_done", done, 1'b0);
      chk("arst_err", err_count, 10'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_check("poke", 16'($urandom), 0, 1'b1);
      run_check("b2b", 16'hFFFF, 0, 1'b0);

      for (int r = 0; r < 3; r++) begin
         run_check("rand", 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
